// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts word-aligned fetch requests and returns
// the instruction after WAIT_STATES extra cycles; a side port loads the memory.
module imem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic        rsp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        busy
);
    // state  | meaning
    // S_IDLE | ready for a request
    // S_WAIT | counting wait states for the accepted request
    // S_RESP | response presented, waiting for rsp_ready
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] word_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS] = '{default: NOP_INSTR};

    logic [29:0] req_word, load_word, cap_word;
    logic        req_err, cap_err, accept, capture, load_ok;
    logic [31:0] rd_data;
    logic        unused_load_lsbs;

    assign req_word         = req_addr[31:2];
    assign load_word        = load_addr[31:2];
    assign unused_load_lsbs = ^load_addr[1:0];
    assign req_err          = (req_addr[1:0] != 2'b00) || (req_word >= 30'(DEPTH_WORDS));
    assign load_ok          = load_en && (load_word < 30'(DEPTH_WORDS));

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign accept    = req_valid && req_ready;

    // With zero wait states the capture happens on the accept edge, straight from req_addr.
    assign cap_word = (state_q == S_IDLE) ? req_word : word_q;
    assign cap_err  = (state_q == S_IDLE) ? req_err  : err_q;
    assign capture  = (state_d == S_RESP) && (state_q != S_RESP);
    assign rd_data  = (load_ok && (load_word == cap_word)) ? load_data
                                                           : mem[cap_word[IW-1:0]];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            word_q    <= 30'd0;
            err_q     <= 1'b0;
            rsp_instr <= NOP_INSTR;
            rsp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                word_q <= req_word;
                err_q  <= req_err;
            end
            if (capture) begin
                rsp_err   <= cap_err;
                rsp_instr <= cap_err ? NOP_INSTR : rd_data;
            end
        end
    end

    // Memory keeps its contents across rst and accepts loads in every state.
    always_ff @(posedge clk) begin
        if (load_ok) mem[load_word[IW-1:0]] <= load_data;
    end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed steps plus randomized requests checked
// against a word-array memory model, on a 2-wait-state and a 0-wait-state build.
module tb_imem_responder;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_instr [2];
    logic        rsp_err   [2];
    logic        load_en   [2];
    logic [31:0] load_addr [2];
    logic [31:0] load_data [2];
    logic        busy      [2];

    int checks = 0;
    int errors = 0;
    int ws [2] = '{2, 0};
    logic [31:0] model_mem [2][DEPTH];

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .NOP_INSTR(NOP)) dut_w2 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_instr(rsp_instr[0]), .rsp_err(rsp_err[0]), .load_en(load_en[0]),
        .load_addr(load_addr[0]), .load_data(load_data[0]), .busy(busy[0]));

    imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .NOP_INSTR(NOP)) dut_w0 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_instr(rsp_instr[1]), .rsp_err(rsp_err[1]), .load_en(load_en[1]),
        .load_addr(load_addr[1]), .load_data(load_data[1]), .busy(busy[1]));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Expected response from the memory rules: misaligned or beyond DEPTH -> NOP + err.
    task automatic model_rsp(input int sel, input logic [31:0] addr,
                             output logic [31:0] ins, output logic err);
        err = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
        ins = err ? NOP : model_mem[sel][addr / 4];
    endtask

    task automatic model_load(input int sel, input logic [31:0] addr, input logic [31:0] data);
        if ((addr / 4) < DEPTH) model_mem[sel][addr / 4] = data;
    endtask

    task automatic do_load(input int sel, input logic [31:0] addr, input logic [31:0] data);
        load_en[sel] = 1'b1; load_addr[sel] = addr; load_data[sel] = data;
        tick();
        load_en[sel] = 1'b0;
        model_load(sel, addr, data);
    endtask

    // Latency is counted in edges from the edge after which the request is presented.
    task automatic do_req(input int sel, input logic [31:0] addr, input int hold, input string tag);
        logic [31:0] ei;
        logic        ee;
        int          lat;
        model_rsp(sel, addr, ei, ee);
        req_addr[sel] = addr; req_valid[sel] = 1'b1;
        chk({tag, "_req_ready"}, 32'(req_ready[sel]), 32'd1);
        tick();
        req_valid[sel] = 1'b0;
        lat = 1;
        while (!rsp_valid[sel] && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(ws[sel] + 1));
        chk({tag, "_instr"}, rsp_instr[sel], ei);
        chk({tag, "_err"}, 32'(rsp_err[sel]), 32'(ee));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_hold_valid"}, 32'(rsp_valid[sel]), 32'd1);
            chk({tag, "_hold_instr"}, rsp_instr[sel], ei);
            chk({tag, "_hold_ready"}, 32'(req_ready[sel]), 32'd0);
        end
        rsp_ready[sel] = 1'b1;
        tick();
        rsp_ready[sel] = 1'b0;
        chk({tag, "_idle_busy"}, 32'(busy[sel]), 32'd0);
        chk({tag, "_idle_ready"}, 32'(req_ready[sel]), 32'd1);
    endtask

    initial begin
        logic [31:0] a, d;
        int seen;
        int n_acc, n_rsp;
        int acc_cyc [4];
        int rsp_cyc [4];
        logic [31:0] s_addr [4];
        logic [31:0] ei;
        logic        ee;

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) model_mem[s][i] = NOP;
            rst[s] = 1'b1; req_valid[s] = 1'b0; req_addr[s] = '0; rsp_ready[s] = 1'b0;
            load_en[s] = 1'b0; load_addr[s] = '0; load_data[s] = '0;
        end
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_rsp_instr", rsp_instr[0], NOP);
        chk("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        rst[0] = 1'b0; rst[1] = 1'b0;
        tick();
        chk("post_rst_ready", 32'(req_ready[0]), 32'd1);

        do_load(0, 32'h0, 32'h0050_0093);
        do_req(0, 32'h0, 0, "t1_basic");
        do_req(0, 32'h6, 0, "t2_misaligned");
        do_req(0, 32'h400, 0, "t2_out_of_range");
        do_req(0, 32'h3FC, 0, "powerup_last_word");
        do_load(0, 32'h4, 32'h0000_0113);
        do_req(0, 32'h4, 5, "t3_backpressure");

        do_load(0, 32'h8, 32'h1111_1111);
        req_addr[0] = 32'h8; req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        tick();
        load_en[0] = 1'b1; load_addr[0] = 32'h8; load_data[0] = 32'hDEAD_BEEF;
        tick();
        load_en[0] = 1'b0;
        model_load(0, 32'h8, 32'hDEAD_BEEF);
        chk("t4_capture_valid", 32'(rsp_valid[0]), 32'd1);
        chk("t4_capture_write_first", rsp_instr[0], 32'hDEAD_BEEF);
        rsp_ready[0] = 1'b1; tick(); rsp_ready[0] = 1'b0;

        req_addr[0] = 32'h8; req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        tick();
        tick();
        chk("t4_resp_valid", 32'(rsp_valid[0]), 32'd1);
        load_en[0] = 1'b1; load_addr[0] = 32'h8; load_data[0] = 32'hCAFE_F00D;
        tick();
        load_en[0] = 1'b0;
        model_load(0, 32'h8, 32'hCAFE_F00D);
        chk("t4_resp_load_old_word", rsp_instr[0], 32'hDEAD_BEEF);
        rsp_ready[0] = 1'b1; tick(); rsp_ready[0] = 1'b0;
        do_req(0, 32'h8, 0, "t4_later_load_landed");

        req_addr[0] = 32'h0; req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        rst[0] = 1'b1;
        load_en[0] = 1'b1; load_addr[0] = 32'h10; load_data[0] = 32'h0A0B_0C0D;
        tick();
        rst[0] = 1'b0; load_en[0] = 1'b0;
        model_load(0, 32'h10, 32'h0A0B_0C0D);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid[0]) seen++;
            tick();
        end
        chk("t5_no_response_after_rst", 32'(seen), 32'd0);
        chk("t5_idle_after_rst", 32'(busy[0]), 32'd0);
        do_req(0, 32'h0, 1, "t5_mem_preserved");
        do_req(0, 32'h10, 0, "t5_load_during_rst");

        for (int i = 0; i < 4; i++) begin
            s_addr[i] = 32'(i * 4);
            do_load(1, s_addr[i], $urandom);
        end
        n_acc = 0; n_rsp = 0;
        rsp_ready[1] = 1'b1;
        for (int c = 0; c < 30 && n_rsp < 4; c++) begin
            req_valid[1] = (n_acc < 4);
            req_addr[1]  = (n_acc < 4) ? s_addr[n_acc] : 32'h0;
            if (rsp_valid[1] && n_rsp < 4) begin
                model_rsp(1, s_addr[n_rsp], ei, ee);
                chk("t6_stream_instr", rsp_instr[1], ei);
                rsp_cyc[n_rsp] = c;
                n_rsp++;
            end
            if (req_valid[1] && req_ready[1]) begin
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            tick();
        end
        req_valid[1] = 1'b0; rsp_ready[1] = 1'b0;
        chk("t6_stream_count", 32'(n_rsp), 32'd4);
        for (int i = 0; i < n_rsp; i++)
            chk("t6_rsp_one_edge", 32'(rsp_cyc[i] - acc_cyc[i]), 32'd1);
        for (int i = 1; i < n_acc; i++)
            chk("t6_accept_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
        do_req(1, 32'h2, 0, "t6_w0_misaligned");

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = ($urandom_range(0, 7) == 0) ? 32'h400 + 32'($urandom_range(0, 255)) * 4
                                                : 32'($urandom_range(0, 31)) * 4;
                d = $urandom;
                do_load(0, a, d);
            end
            case ($urandom_range(0, 5))
                0:       a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
                1:       a = 32'h400 + ($urandom & 32'hFFFF_FFFC);
                2:       a = 32'($urandom_range(0, 255)) * 4;
                default: a = 32'($urandom_range(0, 31)) * 4;
            endcase
            do_req(0, a, $urandom_range(0, 3), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
